// File: rtl/flex_counter_pkg.sv
// Shared types and helpers for the multi-channel flexible counter.
// Direction encoding and packed-slice indexing used by the top and channel modules.
package flex_counter_pkg;

   typedef enum logic {CNT_UP = 1'b0, CNT_DOWN = 1'b1} cnt_dir_e;

   // Low bit of channel ch inside a bus packed as NUM_CH fields of w bits.
   function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned w);
      return ch * w;
   endfunction

endpackage

// File: rtl/multi_flex_counter_if.sv
// Control/status bundle for multi_flex_counter; per-channel fields are packed
// channel i at [i*NUM_CNT_BITS +: NUM_CNT_BITS].
interface multi_flex_counter_if #(
   parameter int unsigned NUM_CNT_BITS = 4,
   parameter int unsigned NUM_CH       = 2
);
   logic [NUM_CH-1:0]              clear;
   logic [NUM_CH-1:0]              count_enable;
   logic [NUM_CH-1:0]              count_dir;
   logic [NUM_CH-1:0]              load;
   logic [NUM_CH*NUM_CNT_BITS-1:0] load_val;
   logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val;
   logic [NUM_CH*NUM_CNT_BITS-1:0] count_out;
   logic [NUM_CH-1:0]              rollover_flag;
   logic                           carry_out;

   modport master (
      output clear, count_enable, count_dir, load, load_val, rollover_val,
      input  count_out, rollover_flag, carry_out
   );

   modport slave (
      input  clear, count_enable, count_dir, load, load_val, rollover_val,
      output count_out, rollover_flag, carry_out
   );
endinterface

// File: rtl/flex_counter_ch.sv
// One flexible rollover counter channel: up/down, synchronous clear/load,
// registered terminal flag and combinational carry for cascading.
module flex_counter_ch
   import flex_counter_pkg::*;
#(
   parameter int unsigned NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  cnt_dir_e                dir,
   input  logic                    clear,
   input  logic                    load,
   input  logic [NUM_CNT_BITS-1:0] load_val,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count,
   output logic                    flag,
   output logic                    carry
);
   localparam int unsigned W = NUM_CNT_BITS;
   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] term;
   logic [W-1:0] count_next;
   logic         flag_next;
   logic         rv_zero;

   always_comb begin
      rv_zero    = (rollover_val == '0);
      term       = (dir == CNT_DOWN) ? ONE : rollover_val;
      count_next = count;
      if (clear) begin
         count_next = '0;
      end else if (load) begin
         count_next = load_val;
      end else if (en) begin
         if (dir == CNT_UP) begin
            count_next = (count == rollover_val) ? ONE : count + ONE;
         end else begin
            count_next = (count == '0 || count == ONE) ? rollover_val : count - ONE;
         end
      end
      // Flag is judged on the value being registered, so it lines up with count.
      flag_next = ~rv_zero & (count_next == term);
      carry     = en & ~clear & ~load & (count == term) & ((dir == CNT_DOWN) | ~rv_zero);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         flag  <= 1'b0;
      end else begin
         count <= count_next;
         flag  <= flag_next;
      end
   end
endmodule

// File: rtl/multi_flex_counter.sv
// NUM_CH independent flexible counters; with CASCADE=1 each channel after the
// first advances only on the previous channel's carry (single-cycle ripple).
module multi_flex_counter
   import flex_counter_pkg::*;
#(
   parameter int unsigned NUM_CNT_BITS = 4,
   parameter int unsigned NUM_CH       = 2,
   parameter bit          CASCADE      = 1'b0
) (
   input logic                 clk,
   input logic                 rst,
   multi_flex_counter_if.slave bus
);
   localparam int unsigned W = NUM_CNT_BITS;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam int unsigned LO = slice_lo(i, W);

      logic         en_eff;
      logic         carry_l;
      logic [W-1:0] count_l;
      logic         flag_l;

      if (CASCADE && i > 0) begin : g_casc
         assign en_eff = bus.count_enable[i] & g_ch[i-1].carry_l;
      end else begin : g_free
         assign en_eff = bus.count_enable[i];
      end

      flex_counter_ch #(
         .NUM_CNT_BITS(W)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .en           (en_eff),
         .dir          (cnt_dir_e'(bus.count_dir[i])),
         .clear        (bus.clear[i]),
         .load         (bus.load[i]),
         .load_val     (bus.load_val[LO +: W]),
         .rollover_val (bus.rollover_val[LO +: W]),
         .count        (count_l),
         .flag         (flag_l),
         .carry        (carry_l)
      );

      assign bus.count_out[LO +: W] = count_l;
      assign bus.rollover_flag[i]   = flag_l;
   end

   assign bus.carry_out = g_ch[NUM_CH-1].carry_l;
endmodule

// File: doc/multi_flex_counter.md
Name: multi_flex_counter

Overview:
Parametrised successor to the single flexible rollover counter. It holds NUM_CH independent counters of NUM_CNT_BITS each. Each channel adds up/down mode, synchronous load, and a registered rollover flag. An optional cascade mode chains each channel's carry into the next, for wide or multi-stage timers such as bit/byte/packet counting in the serial and timer blocks.

Parameters:
NUM_CNT_BITS, 4, width of each channel counter
NUM_CH, 2, number of channels (>=1)
CASCADE, 0, 1 = channel i>0 advances only when channel i-1 carries; 0 = channels independent

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
clear  input  NUM_CH  per-channel synchronous clear
count_enable  input  NUM_CH  per-channel count enable
count_dir  input  NUM_CH  per-channel direction; 0 = up, 1 = down
load  input  NUM_CH  per-channel synchronous load strobe
load_val  input  NUM_CH*NUM_CNT_BITS  load values; channel i at [i*W +: W]
rollover_val  input  NUM_CH*NUM_CNT_BITS  terminal values, packed the same way
count_out  output  NUM_CH*NUM_CNT_BITS  registered counts, packed the same way
rollover_flag  output  NUM_CH  registered; high while the channel count equals its terminal
carry_out  output  1  combinational carry of channel NUM_CH-1

Behaviour:
- W = NUM_CNT_BITS. Per-channel terminal T = rollover_val (up) or 1 (down).
- Reset (rst high, asynchronous): every count_out = 0, every rollover_flag = 0. These values hold while rst is high. Reset mid-count discards all state.
- Per-channel next-count priority: clear > load > effective enable > hold.
  - clear: next = 0.
  - load: next = load_val.
  - Enabled and up:
    - count == rollover_val: next = 1.
    - else: next = count + 1, wrapping 2^W-1 -> 0.
  - Enabled and down:
    - count == 1 or count == 0: next = rollover_val.
    - else: next = count - 1.
  - Otherwise: hold.
- Effective enable:
  - CASCADE = 0: en_i = count_enable[i].
  - CASCADE = 1: en_0 = count_enable[0]; en_i = count_enable[i] & carry_{i-1}.
- carry_i = en_i & ~clear[i] & ~load[i] & (count_i == T_i), and rollover_val_i != 0 for up mode. It is combinational, and the chain ripples through all channels in one cycle. carry_out = carry_{NUM_CH-1}.
- rollover_flag_i is registered: it equals (next_count == T_i) evaluated with the current direction. It is therefore always coincident with count_out (zero-latency relative to the count). It is forced to 0 when rollover_val_i == 0.
- rollover_val == 0:
  - Up: counts freely modulo 2^W; flag and carry never assert.
  - Down: count at 0 or 1 reloads to 0, then stays 0.
- rollover_val changed below the current count (up): no early wrap. The counter runs to 2^W-1, wraps to 0, then continues to the new terminal.
- count_dir changing mid-count takes effect on the next enabled cycle. No reload occurs on a direction change.
- Flag is re-evaluated after clear or load. Example: load_val == rollover_val in up mode sets the flag next cycle.
- Channels are independent apart from the cascade chain. Simultaneous clear on channel i and a carry from i-1: clear wins, and carry_i = 0.

Decomposition:
- Package flex_counter_pkg:
  - typedef enum logic {CNT_UP = 1'b0, CNT_DOWN = 1'b1} cnt_dir_e.
  - localparam helper for packed slice indexing.
- Sub-module flex_counter_ch: one channel. It takes en, dir, clear, load, load_val, rollover_val and produces count, flag and carry. The top module instantiates NUM_CH copies in a generate loop and wires the cascade chain.

Test Plan:
- Reset and basic up count. W=4, CH0 up, rollover_val=5, enable held.
  - Count sequence from reset: 0,1,2,3,4,5,1,2.
  - rollover_flag high exactly on the count==5 cycles.
- Down mode. rollover_val=3, dir=1, enable held from reset.
  - Count sequence: 0 -> 3,2,1,3,2,1.
  - Flag high on each count==1 cycle.
- Priority. On a single edge, assert clear=1, load=1 (load_val=9) and enable=1: count -> 0.
  - Next edge, load only: count -> 9.
  - Next edge, with rollover_val=9: flag = 1.
- Cascade, CASCADE=1, NUM_CH=2, both up, rollover_val=3/2, both enables held.
  - CH1 steps only on cycles where CH0 == 3.
  - After 9 enabled cycles from 0/0: CH0 = 3, CH1 = 2.
  - carry_out high in the same cycle as {CH0=3, CH1=2}.
- Edge values.
  - rollover_val=0, up: count wraps 15 -> 0 and the flag never asserts.
  - rollover_val lowered from 10 to 4 while count=7: count continues 8..15,0,1..4, and the flag rises at 4.
- Asynchronous reset mid-count. Assert rst between clock edges while count=6 and flag=0.
  - count_out = 0 and flag = 0 immediately, held through the next edges.
  - After release, counting resumes 1,2,...
